// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: pops a FIFO with one-cycle read latency into a 3-entry
// skid buffer and presents it as a valid/ready stream. Optional macro FIFO_RD_CTRL_COUNT_EN adds word_count.
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  read_en,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  empty,
    input  logic                  error,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  err_flag
`ifdef FIFO_RD_CTRL_COUNT_EN
    ,
    output logic [15:0]           word_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, ERR} state_t;

    state_t                state_q, state_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  err_flag_q, err_flag_d;
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    logic [2:0]            pending;
    logic                  xfer;

    // Words already committed (buffered plus the one arriving) bound the pop decision.
    assign pending  = {1'b0, occ_q} + {2'b00, inflight_q};
    assign read_en  = (state_q == RUN) && !empty && (pending < 3'd3);
    assign m_valid  = (occ_q != 2'd0);
    assign m_data   = buf_q[0];
    assign err_flag = err_flag_q;
    assign xfer     = m_valid && m_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN: begin
                if (error)        state_d = ERR;
                else if (!enable) state_d = DRAIN;
            end
            DRAIN: begin
                if (error)                                state_d = ERR;
                else if (enable)                          state_d = RUN;
                else if (!inflight_q && occ_q == 2'd0)    state_d = IDLE;
            end
            ERR:     if (!enable && !inflight_q && occ_q == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic [1:0] wr_idx;
        buf_d      = buf_q;
        occ_d      = occ_q;
        wr_idx     = occ_q;
        inflight_d = read_en;
        err_flag_d = err_flag_q | error;
        // Shift out the head first so an arriving word lands behind the survivors.
        if (xfer) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            wr_idx   = occ_q - 2'd1;
            occ_d    = occ_q - 2'd1;
        end
        if (inflight_q) begin
            for (int i = 0; i < 3; i++) begin
                if (wr_idx == i[1:0]) buf_d[i] = data_out;
            end
            occ_d = occ_d + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            err_flag_q <= 1'b0;
            for (int i = 0; i < 3; i++) buf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            err_flag_q <= err_flag_d;
            for (int i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
        end
    end

`ifdef FIFO_RD_CTRL_COUNT_EN
    logic [15:0] word_count_q, word_count_d;

    always_comb begin
        word_count_d = word_count_q;
        if (xfer && word_count_q != 16'hFFFF) word_count_d = word_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) word_count_q <= 16'd0;
        else      word_count_q <= word_count_d;
    end

    assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: behavioural FIFO with one-cycle read latency
// feeds the DUT; a scoreboard queue holds every loaded word in expected delivery order.
module tb_fifo_rd_ctrl;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, enable, read_en, empty, error, m_valid, m_ready, err_flag;
    logic [DW-1:0] data_out, m_data;
`ifdef FIFO_RD_CTRL_COUNT_EN
    logic [15:0]   word_count;
`endif

    int            ncomp = 0;
    int            nfail = 0;
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    int            cyc = 0, pop_cnt = 0, xfer_cnt = 0;
    int            first_re = -1, first_mv = -1, first_x = -1, last_x = -1;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    fifo_rd_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .read_en  (read_en),
        .data_out (data_out),
        .empty    (empty),
        .error    (error),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err_flag (err_flag)
`ifdef FIFO_RD_CTRL_COUNT_EN
        ,
        .word_count (word_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ncomp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        exp_q.push_back(w);
        empty = 1'b0;
    endtask

    task automatic mark();
        pop_cnt  = 0;
        xfer_cnt = 0;
        first_re = -1;
        first_mv = -1;
        first_x  = -1;
        last_x   = -1;
    endtask

    // One clock: observe on the falling edge, then answer any pop just after the rising edge.
    task automatic tick();
        logic          re;
        logic [DW-1:0] e;
        @(negedge clk);
        cyc++;
        re = read_en;
        if (re && first_re < 0) first_re = cyc;
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (hold_v && m_valid) chk("hold_stable", m_data, hold_d);
        if (m_valid && m_ready) begin
            xfer_cnt++;
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            chk("xfer_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("xfer_data", m_data, e);
            end
        end
        hold_v = m_valid && !m_ready;
        hold_d = m_data;
        @(posedge clk);
        #1;
        if (re) begin
            chk("pop_nonempty", fifo_q.size() != 0, 1);
            if (fifo_q.size() != 0) data_out = fifo_q.pop_front();
            pop_cnt++;
        end
        empty = (fifo_q.size() == 0);
    endtask

    initial begin
        rst      = 1'b0;
        enable   = 1'b0;
        m_ready  = 1'b0;
        error    = 1'b0;
        empty    = 1'b1;
        data_out = '0;
        #2;
        chk("rst_read_en", read_en, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_flag", err_flag, 0);
`ifdef FIFO_RD_CTRL_COUNT_EN
        chk("rst_word_count", word_count, 0);
`endif
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("idle_read_en", read_en, 0);

        // Streaming: four words, m_ready held high.
        mark();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44);
        m_ready = 1'b1;
        enable  = 1'b1;
        repeat (10) tick();
        chk("t1_latency", first_mv - first_re, 2);
        chk("t1_first_xfer", first_x - first_re, 2);
        chk("t1_burst_span", last_x - first_x, 3);
        chk("t1_xfers", xfer_cnt, 4);
        chk("t1_drained", exp_q.size(), 0);
        chk("t1_empty_no_valid", m_valid, 0);
`ifdef FIFO_RD_CTRL_COUNT_EN
        chk("t1_word_count", word_count, 4);
`endif

        // Backpressure: five words, only three may be popped.
        mark();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(8'hA0 + 8'(i));
        repeat (8) tick();
        chk("t2_pops", pop_cnt, 3);
        chk("t2_read_en_full", read_en, 0);
        chk("t2_m_valid", m_valid, 1);
        chk("t2_head", m_data, 8'hA0);
        chk("t2_fifo_left", fifo_q.size(), 2);
        m_ready = 1'b1;
        repeat (10) tick();
        chk("t2_pops_total", pop_cnt, 5);
        chk("t2_xfers", xfer_cnt, 5);
        chk("t2_drained", exp_q.size(), 0);

        // Disable with one word in flight and two buffered.
        mark();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) load(8'hB0 + 8'(i));
        repeat (3) tick();
        chk("t3_pops_before", pop_cnt, 3);
        enable  = 1'b0;
        pop_cnt = 0;
        repeat (3) tick();
        m_ready = 1'b1;
        repeat (6) tick();
        chk("t3_no_pops", pop_cnt, 0);
        chk("t3_xfers", xfer_cnt, 3);
        chk("t3_exp_left", exp_q.size(), 1);
        chk("t3_m_valid", m_valid, 0);
        chk("t3_read_en", read_en, 0);
        enable = 1'b1;
        repeat (6) tick();
        chk("t3_restart_xfers", xfer_cnt, 4);
        chk("t3_drained", exp_q.size(), 0);

        // One-cycle error pulse while streaming.
        mark();
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) load(8'hC0 + 8'(i));
        repeat (3) tick();
        error = 1'b1;
        tick();
        error = 1'b0;
        chk("t4_err_flag", err_flag, 1);
        chk("t4_read_en_off", read_en, 0);
        chk("t4_pops", pop_cnt, 4);
        pop_cnt = 0;
        repeat (8) tick();
        chk("t4_no_pops", pop_cnt, 0);
        chk("t4_exp_left", exp_q.size(), 2);
        chk("t4_fifo_left", fifo_q.size(), 2);
        chk("t4_err_sticky", err_flag, 1);
        chk("t4_m_valid", m_valid, 0);
        enable = 1'b0;
        repeat (3) tick();
        enable = 1'b1;
        repeat (8) tick();
        chk("t4_recovered", exp_q.size(), 0);
        chk("t4_err_sticky2", err_flag, 1);

        // Reset while two words are buffered and one is in flight.
        mark();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) load(8'hD0 + 8'(i));
        repeat (3) tick();
        chk("t5_pre_valid", m_valid, 1);
        rst = 1'b0;
        #1;
        chk("t5_rst_m_valid", m_valid, 0);
        chk("t5_rst_read_en", read_en, 0);
        chk("t5_rst_m_data", m_data, 0);
        chk("t5_rst_err_flag", err_flag, 0);
        fifo_q.delete();
        exp_q.delete();
        empty    = 1'b1;
        data_out = '0;
        hold_v   = 1'b0;
        tick();
        rst = 1'b1;
        mark();
        load(8'h55);
        m_ready = 1'b1;
        repeat (6) tick();
        chk("t5_xfers", xfer_cnt, 1);
        chk("t5_drained", exp_q.size(), 0);
`ifdef FIFO_RD_CTRL_COUNT_EN
        chk("t5_word_count", word_count, 1);

        for (int i = 0; i < 70010; i++) begin
            if (fifo_q.size() < 4) load(8'(i));
            tick();
        end
        chk("count_saturated", word_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end
endmodule
